// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch unit. Issues sequential word reads to instruction memory,
// buffers returned words (tagged with their word-address PC) in a small
// prefetch queue and hands them to the decoder over a valid/ready handshake.
// A redirect flushes the queue, restarts fetch at a new PC and arranges for
// every response still in flight to be discarded when it returns.
//
// Parameters
//   DEPTH     prefetch queue entries (power of two, >= 2)
//   PC_W      word-address PC width
//   RESET_PC  fetch PC after reset
//
// Ports
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   imem_req_valid  out  read request valid
//   imem_req_ready  in   memory accepts the request
//   imem_addr       out  word address of the request
//   imem_rsp_valid  in   read data valid (in request order, latency >= 1)
//   imem_rsp_data   in   instruction word
//   inst_valid      out  instruction available to the decoder
//   inst_ready      in   decoder consumes the instruction
//   instruction     out  instruction word at the queue head
//   inst_pc         out  word address of instruction
//   redirect_valid  in   flush and restart fetch
//   redirect_pc     in   new fetch PC
//   fetch_bubbles   out  (FELIS_FETCH_PERF_EN only) saturating count of
//                        cycles with no instruction offered and no redirect
//
// Build option
//   FELIS_FETCH_PERF_EN  adds the fetch_bubbles counter and output port.
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = 14,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,

    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,

    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     instruction,
    output logic [PC_W-1:0] inst_pc,

    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc
`ifdef FELIS_FETCH_PERF_EN
    ,
    output logic [31:0]     fetch_bubbles
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
    localparam logic [CW:0]     CREDITS = (CW+1)'(DEPTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] tail_pc_q,  tail_pc_d;
    logic [CW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]   outst_q,    outst_d;
    logic [CW-1:0]   drop_q,     drop_d;
    logic [31:0]     word_q [DEPTH];
    logic [31:0]     word_d [DEPTH];
    logic [PC_W-1:0] pc_q   [DEPTH];
    logic [PC_W-1:0] pc_d   [DEPTH];

    // -----------------------------------------------------------------------
    // Derived control
    // -----------------------------------------------------------------------
    logic [CW-1:0] occupancy;
    logic [CW:0]   in_use;
    logic          queue_empty;
    logic          req_fire;
    logic          pop;
    logic          rsp_drop;
    logic          rsp_keep;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign occupancy   = wr_ptr_q - rd_ptr_q;
    // Every accepted request owns a queue slot until its word is popped (or
    // dropped), so the queue can never overflow.
    assign in_use      = {1'b0, occupancy} + {1'b0, outst_q};
    assign queue_empty = (wr_ptr_q == rd_ptr_q);

    assign imem_req_valid = (in_use < CREDITS);
    assign imem_addr      = fetch_pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign pop      = inst_valid && inst_ready;

    // Responses owed to a flushed stream are swallowed first; a response in
    // the redirect cycle itself is also stale.
    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign rsp_keep = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    assign inst_valid  = !queue_empty;
    assign instruction = word_q[rd_idx];
    assign inst_pc     = pc_q[rd_idx];

    // -----------------------------------------------------------------------
    // Next state
    // -----------------------------------------------------------------------
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        tail_pc_d  = tail_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_d     = drop_q;
        word_d     = word_q;
        pc_d       = pc_q;

        outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + PC_ONE;
        end

        if (rsp_keep) begin
            word_d[wr_idx] = imem_rsp_data;
            pc_d[wr_idx]   = tail_pc_q;
            wr_ptr_d       = wr_ptr_q + CNT_ONE;
            tail_pc_d      = tail_pc_q + PC_ONE;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + CNT_ONE;
        end

        if (rsp_drop) begin
            drop_d = drop_q - CNT_ONE;
        end

        // Redirect overrides everything above. Whatever is still outstanding
        // after this cycle (including a request accepted right now with the
        // old address) belongs to the abandoned stream and must be dropped.
        if (redirect_valid) begin
            rd_ptr_d   = wr_ptr_q;
            wr_ptr_d   = wr_ptr_q;
            fetch_pc_d = redirect_pc;
            tail_pc_d  = redirect_pc;
            drop_d     = outst_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            tail_pc_q  <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tail_pc_q  <= tail_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            word_q     <= word_d;
            pc_q       <= pc_d;
        end
    end

`ifdef FELIS_FETCH_PERF_EN
    // -----------------------------------------------------------------------
    // Fetch bubble counter (saturating)
    // -----------------------------------------------------------------------
    logic [31:0] bubbles_q, bubbles_d;

    always_comb begin
        bubbles_d = bubbles_q;
        if (!inst_valid && !redirect_valid && (bubbles_q != 32'hFFFF_FFFF)) begin
            bubbles_d = bubbles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubbles_q <= '0;
        end else begin
            bubbles_q <= bubbles_d;
        end
    end

    assign fetch_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//
// Directed bench for inst_fetch. A bench-side memory answers the DUT's
// requests in order after a programmable latency with word = 0x20000000|addr.
// A transaction-level model (expected-instruction queue plus an in-flight
// list tagged with a redirect epoch) predicts every output each cycle; a few
// literal expectations pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

    localparam int              DEPTH  = 4;
    localparam int              PC_W   = 14;
    localparam logic [PC_W-1:0] RST_PC = 14'h010;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b0;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [31:0]     imem_rsp_data = '0;
    logic            inst_valid;
    logic            inst_ready = 1'b0;
    logic [31:0]     instruction;
    logic [PC_W-1:0] inst_pc;
    logic            redirect_valid = 1'b0;
    logic [PC_W-1:0] redirect_pc = '0;
`ifdef FELIS_FETCH_PERF_EN
    logic [31:0]     fetch_bubbles;
`endif

    always #5 clk = ~clk;

    inst_fetch #(
        .DEPTH    (DEPTH),
        .PC_W     (PC_W),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FELIS_FETCH_PERF_EN
        ,
        .fetch_bubbles  (fetch_bubbles)
`endif
    );

    // -----------------------------------------------------------------------
    // Bookkeeping
    // -----------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_count = 0;

    // bench memory
    int              mem_lat  = 1;
    int              last_due = -1;
    logic [PC_W-1:0] mem_addr_q [$];
    int              mem_due_q  [$];

    // model
    typedef struct packed {
        logic [31:0]     word;
        logic [PC_W-1:0] pc;
    } ent_t;

    typedef struct packed {
        logic [31:0]     epoch;
        logic [PC_W-1:0] addr;
    } fl_t;

    ent_t            exp_q  [$];
    fl_t             infl_q [$];
    logic [PC_W-1:0] m_fetch;
    logic [31:0]     m_epoch;
    logic [31:0]     m_bubbles;

    function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
        return 32'h2000_0000 | {{(32-PC_W){1'b0}}, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -----------------------------------------------------------------------
    // Per-cycle compare + model/memory update, evaluated at the falling edge
    // with this cycle's inputs stable.
    // -----------------------------------------------------------------------
    task automatic model_step();
        bit   exp_valid;
        bit   exp_req;
        bit   macc;
        bit   mpop;
        int   due;
        fl_t  f;

        exp_valid = (exp_q.size() != 0);
        exp_req   = ((exp_q.size() + infl_q.size()) < DEPTH);

        check("inst_valid", {31'b0, inst_valid}, {31'b0, exp_valid});
        check("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
        check("imem_addr", {18'b0, imem_addr}, {18'b0, m_fetch});
        if (exp_valid) begin
            check("instruction", instruction, exp_q[0].word);
            check("inst_pc", {18'b0, inst_pc}, {18'b0, exp_q[0].pc});
        end
`ifdef FELIS_FETCH_PERF_EN
        check("fetch_bubbles", fetch_bubbles, m_bubbles);
        if (!exp_valid && !redirect_valid && (m_bubbles != 32'hFFFF_FFFF)) m_bubbles++;
`endif

        // memory answers whatever the DUT actually issued
        if (imem_req_valid && imem_req_ready) begin
            acc_count++;
            due = (last_due + 1 > cyc + mem_lat) ? last_due + 1 : cyc + mem_lat;
            mem_addr_q.push_back(imem_addr);
            mem_due_q.push_back(due);
            last_due = due;
        end

        macc = exp_req && imem_req_ready;
        mpop = exp_valid && inst_ready;

        if (mpop) void'(exp_q.pop_front());
        if (macc) begin
            infl_q.push_back('{epoch: m_epoch, addr: m_fetch});
            m_fetch++;
        end
        if (imem_rsp_valid) begin
            if (infl_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_rsp: response with no request in flight (cycle %0d)", cyc);
            end else begin
                f = infl_q.pop_front();
                if ((f.epoch == m_epoch) && !redirect_valid)
                    exp_q.push_back('{word: mem_word(f.addr), pc: f.addr});
            end
        end
        if (redirect_valid) begin
            exp_q.delete();
            m_epoch++;
            m_fetch = redirect_pc;
        end
    endtask

    task automatic drive_mem();
        if ((mem_due_q.size() != 0) && (mem_due_q[0] <= cyc)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr_q[0]);
            void'(mem_due_q.pop_front());
            void'(mem_addr_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        drive_mem();
    endtask

    task automatic wait_valid(input int maxc, input string tag);
        int n;
        n = 0;
        while (!inst_valid && (n < maxc)) begin
            tick();
            n++;
        end
        checks++;
        if (!inst_valid) begin
            errors++;
            $display("FAIL %s: inst_valid still 0 after %0d cycles, required 1", tag, maxc);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        mem_addr_q.delete();
        mem_due_q.delete();
        exp_q.delete();
        infl_q.delete();
        last_due  = -1;
        m_fetch   = RST_PC;
        m_epoch   = '0;
        m_bubbles = '0;
        #1;
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("rst_imem_addr", {18'b0, imem_addr}, 32'h10);
        check("rst_instruction", instruction, 32'd0);
        check("rst_inst_pc", {18'b0, inst_pc}, 32'd0);
`ifdef FELIS_FETCH_PERF_EN
        check("rst_fetch_bubbles", fetch_bubbles, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        logic [15:0] rdy_pat;
        int          n;
        logic [31:0] b0;

        #2;
        do_reset();

        // reset and stream: 1-cycle memory, decoder always ready
        mem_lat = 1; inst_ready = 1'b1; imem_req_ready = 1'b1;
        tick();
        check("s1_cycle1_valid", {31'b0, inst_valid}, 32'd0);
        tick();
        check("s1_cycle2_valid", {31'b0, inst_valid}, 32'd1);
        check("s1_first_pc", {18'b0, inst_pc}, 32'h10);
        check("s1_first_word", instruction, 32'h2000_0010);
        tick();
        check("s1_second_pc", {18'b0, inst_pc}, 32'h11);
        tick();
        check("s1_third_pc", {18'b0, inst_pc}, 32'h12);
        check("s1_third_word", instruction, 32'h2000_0012);
        repeat (8) tick();

        // backpressure: drain, then stall the decoder for 10 cycles
        imem_req_ready = 1'b0;
        repeat (4) tick();
        check("bp_drained", {31'b0, inst_valid}, 32'd0);
        inst_ready = 1'b0; imem_req_ready = 1'b1; acc_count = 0;
        repeat (10) tick();
        check("bp_req_count", acc_count, 32'd4);
        check("bp_req_valid_low", {31'b0, imem_req_valid}, 32'd0);
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_drain_no_gap", {31'b0, inst_valid}, 32'd1);
            tick();
        end

        // redirect with three reads in flight on a 3-cycle memory
        imem_req_ready = 1'b0;
        repeat (8) tick();
        mem_lat = 3; imem_req_ready = 1'b1;
        repeat (3) tick();
        redirect_valid = 1'b1; redirect_pc = 14'h200;
        tick();
        redirect_valid = 1'b0;
        check("rd_valid_low", {31'b0, inst_valid}, 32'd0);
        check("rd_addr", {18'b0, imem_addr}, 32'h200);
        wait_valid(20, "rd_first_wait");
        check("rd_first_pc", {18'b0, inst_pc}, 32'h200);
        check("rd_first_word", instruction, 32'h2000_0200);
        tick();
        wait_valid(20, "rd_second_wait");
        check("rd_second_pc", {18'b0, inst_pc}, 32'h201);

        // pop, response and redirect in the same cycle
        mem_lat = 1;
        n = 0;
        while (!(inst_valid && imem_rsp_valid) && (n < 20)) begin
            tick();
            n++;
        end
        check("sim_setup", {31'b0, inst_valid && imem_rsp_valid}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 14'h123;
        tick();
        redirect_valid = 1'b0;
        check("sim_valid_low", {31'b0, inst_valid}, 32'd0);
        check("sim_addr", {18'b0, imem_addr}, 32'h123);
        wait_valid(20, "sim_wait");
        check("sim_next_pc", {18'b0, inst_pc}, 32'h123);

        // PC wrap-around
        redirect_valid = 1'b1; redirect_pc = 14'h3FFE;
        tick();
        redirect_valid = 1'b0;
        wait_valid(20, "wrap_wait0");
        check("wrap_pc0", {18'b0, inst_pc}, 32'h3FFE);
        tick();
        wait_valid(20, "wrap_wait1");
        check("wrap_pc1", {18'b0, inst_pc}, 32'h3FFF);
        tick();
        wait_valid(20, "wrap_wait2");
        check("wrap_pc2", {18'b0, inst_pc}, 32'h0000);
        check("wrap_word2", instruction, 32'h2000_0000);

        // irregular decoder readiness on a 2-cycle memory, redirect mid-stream
        mem_lat = 2;
        rdy_pat = 16'b1011_0010_1110_0101;
        for (int i = 0; i < 16; i++) begin
            inst_ready     = rdy_pat[i];
            redirect_valid = (i == 7);
            redirect_pc    = 14'h050;
            tick();
        end
        redirect_valid = 1'b0; inst_ready = 1'b1;

        // back-to-back redirects: the last one wins
        redirect_valid = 1'b1; redirect_pc = 14'h300;
        tick();
        redirect_pc = 14'h340;
        tick();
        redirect_valid = 1'b0;
        check("b2b_addr", {18'b0, imem_addr}, 32'h340);
        wait_valid(20, "b2b_wait");
        check("b2b_pc", {18'b0, inst_pc}, 32'h340);
        tick();
        wait_valid(20, "b2b_wait2");
        check("b2b_pc2", {18'b0, inst_pc}, 32'h341);

`ifdef FELIS_FETCH_PERF_EN
        // perf counter: memory stalled after the queue drains
        imem_req_ready = 1'b0;
        repeat (6) tick();
        check("perf_drained", {31'b0, inst_valid}, 32'd0);
        b0 = m_bubbles;
        repeat (7) tick();
        check("perf_bubbles_plus7", fetch_bubbles, b0 + 32'd7);
        imem_req_ready = 1'b1;
`else
        b0 = '0;
`endif

        // reset in the middle of a stream
        mem_lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        repeat (3) tick();
        do_reset();
        wait_valid(10, "rst2_wait");
        check("rst2_first_pc", {18'b0, inst_pc}, 32'h10);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
